pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB).
//  Carries a control bundle and a data bundle between stages.
//  Adds valid/ready handshake, optional 2-entry skid buffer, synchronous flush with bubble
//  injection, and a saturating stall counter.
//  Replaces fixed-width per-stage registers that have no stall or flush capability.
// PARAMETERS
//  DATA_W       96      width of data bundle (ALU results, PC+4, operands, immediate)
//  CTRL_W       10      width of control bundle (write-enables, WB source, mem flags, dst reg)
//  BUBBLE_CTRL  0       control value presented while stage holds no valid instruction
//  SKID         1       1: registered in_ready with 2-entry skid; 0: single entry, comb. ready
//  CNT_W        16      width of stall counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous active-high reset
//  in_valid   in   1        upstream stage presents an instruction
//  in_ready   out  1        stage accepts this cycle (transfer = in_valid & in_ready)
//  in_ctrl    in   CTRL_W   upstream control bundle
//  in_data    in   DATA_W   upstream data bundle
//  flush      in   1        discard all held entries (branch/exception squash)
//  out_valid  out  1        stage holds a valid instruction for downstream
//  out_ready  in   1        downstream consumes (transfer = out_valid & out_ready)
//  out_ctrl   out  CTRL_W   control bundle; BUBBLE_CTRL when out_valid=0
//  out_data   out  DATA_W   data bundle; holds last value when out_valid=0
//  stall_cnt  out  CNT_W    cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//  Reset (async, rst=1):
//   - out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, stall_cnt=0, skid entry empty.
//   - in_ready=1 once rst deasserts (SKID=1: registered 1; SKID=0: comb. from out_valid=0).
//  Latency and ordering:
//   - 1 cycle from input transfer to out_valid.
//   - Strict FIFO order; no entry dropped or duplicated except by flush.
//  SKID=1 state machine (main reg M, skid reg S):
//   - EMPTY: M,S invalid; in_ready=1. Input xfer -> FULL.
//   - FULL: M valid, S invalid; in_ready=1.
//       in xfer & out xfer   -> FULL, M<=in.
//       in xfer & ~out_ready -> SKID, S<=in.
//       out xfer only        -> EMPTY.
//   - SKID: M,S valid; in_ready=0.
//       out xfer -> FULL, M<=S.
//       else hold.
//   - in_ready is a flop: 1 in EMPTY/FULL, 0 in SKID. No comb. path out_ready->in_ready.
//  SKID=0:
//   - Single register M; in_ready = ~out_valid | out_ready (combinational).
//   - States EMPTY/FULL only.
//  Flush:
//   - Synchronous; next edge -> EMPTY, out_valid=0, out_ctrl=BUBBLE_CTRL.
//   - Flush beats a simultaneous input transfer: that instruction is discarded.
//   - A simultaneous output transfer still counts as consumed downstream.
//   - in_ready=1 on the cycle after flush.
//  Stall counter:
//   - +1 per cycle with out_valid=1 & out_ready=0.
//   - Saturates at 2^CNT_W-1; not cleared by flush, only by rst.
//  Invalid-bundle rules:
//   - out_ctrl forced to BUBBLE_CTRL whenever out_valid=0, so write/mem enables are inert
//     downstream.
//   - out_data not cleared on empty/flush: no extra mux on the datapath.
//  rst asserted mid-transfer: all entries lost, outputs take reset values immediately.
// TESTING
//  1. Reset, then push ctrl=0x3A5, data=0x1234 with out_ready=1
//     -> out_valid=1 next cycle with same values; stall_cnt=0.
//  2. out_ready=0, push A then B (SKID=1)
//     -> in_ready drops after B; raising out_ready delivers A then B in order;
//        stall_cnt = number of stalled cycles.
//  3. State SKID (A,B held), flush=1 with in_valid=1 carrying C
//     -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1; C never appears.
//  4. Back-to-back stream of 8 items, out_ready=1 always
//     -> 8 consecutive out_valid cycles, throughput 1/cycle, in_ready never 0.
//  5. CNT_W=4, hold out_ready=0 for 20 cycles with valid entry -> stall_cnt sticks at 15.
//  6. SKID=0, out_valid=1, out_ready=0
//     -> in_ready=0 same cycle; assert rst mid-cycle -> out_valid=0 immediately.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between stages: valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush with bubble injection, stall counter.
module pipe_stage_elastic #(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 10,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter bit                 SKID        = 1'b1,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state;
  logic              outValidQ;
  logic              inReadyQ;
  logic [CTRL_W-1:0] mCtrl;
  logic [DATA_W-1:0] mData;
  logic [CTRL_W-1:0] sCtrl;
  logic [DATA_W-1:0] sData;
  logic [CNT_W-1:0]  stallCnt;
  logic              inXfer;

  // Without a skid entry the stage can only accept when it is empty or draining.
  assign in_ready  = SKID ? inReadyQ : (~outValidQ | out_ready);
  assign inXfer    = in_valid & in_ready;
  assign out_valid = outValidQ;
  assign out_ctrl  = mCtrl;
  assign out_data  = mData;
  assign stall_cnt = stallCnt;

  // mCtrl is rewritten to BUBBLE_CTRL on every transition to empty, so the
  // control output is inert without a mux after the flop; mData simply holds.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_EMPTY;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      mCtrl     <= BUBBLE_CTRL;
      mData     <= '0;
      sCtrl     <= BUBBLE_CTRL;
      sData     <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      mCtrl     <= BUBBLE_CTRL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (inXfer) begin
            state     <= ST_FULL;
            outValidQ <= 1'b1;
            mCtrl     <= in_ctrl;
            mData     <= in_data;
          end
        end
        ST_FULL: begin
          if (inXfer && out_ready) begin
            mCtrl <= in_ctrl;
            mData <= in_data;
          end else if (inXfer && SKID) begin
            state    <= ST_SKID;
            inReadyQ <= 1'b0;
            sCtrl    <= in_ctrl;
            sData    <= in_data;
          end else if (out_ready) begin
            state     <= ST_EMPTY;
            outValidQ <= 1'b0;
            mCtrl     <= BUBBLE_CTRL;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state    <= ST_FULL;
            inReadyQ <= 1'b1;
            mCtrl    <= sCtrl;
            mData    <= sData;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          outValidQ <= 1'b0;
          inReadyQ  <= 1'b1;
          mCtrl     <= BUBBLE_CTRL;
        end
      endcase
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (outValidQ && !out_ready && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue model checked every cycle against a skid,
// a 4-bit-counter skid, and a no-skid instance, plus directed literal checks.
module tb_pipe_stage_elastic;

  localparam int              DW  = 96;
  localparam int              CW  = 10;
  localparam logic [CW-1:0]   BUB = 10'h2C3;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdyA, vldA, rdy4, vld4, rdyZ, vldZ;
  logic [CW-1:0] ctlA, ctl4, ctlZ;
  logic [DW-1:0] datA, dat4, datZ;
  logic [15:0]   cntA, cntZ;
  logic [3:0]    cnt4;

  int nErr = 0;
  int nChecks = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyA), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(vldA), .out_ready(out_ready),
    .out_ctrl(ctlA), .out_data(datA), .stall_cnt(cntA));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(vld4), .out_ready(out_ready),
    .out_ctrl(ctl4), .out_data(dat4), .stall_cnt(cnt4));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyZ), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(vldZ), .out_ready(out_ready),
    .out_ctrl(ctlZ), .out_data(datZ), .stall_cnt(cntZ));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of held entries, capacity 2 with skid, 1 without.
  ent_t qA[$];
  ent_t qZ[$];
  int   mCntA = 0, mCnt4 = 0, mCntZ = 0;
  logic [DW-1:0] lastA = '0, lastZ = '0;
  bit   mRdyA, mRdyZ;
  ent_t e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qA.delete();
      qZ.delete();
      mCntA = 0; mCnt4 = 0; mCntZ = 0;
      lastA = '0; lastZ = '0;
    end else begin
      mRdyA = qA.size() < 2;
      mRdyZ = (qZ.size() == 0) || out_ready;
      e.c = in_ctrl;
      e.d = in_data;
      if (qA.size() > 0 && !out_ready) begin
        if (mCntA < 65535) mCntA++;
        if (mCnt4 < 15) mCnt4++;
      end
      if (qZ.size() > 0 && !out_ready && mCntZ < 65535) mCntZ++;
      if (flush) begin
        qA.delete();
        qZ.delete();
      end else begin
        if (qA.size() > 0 && out_ready) void'(qA.pop_front());
        if (in_valid && mRdyA) qA.push_back(e);
        if (qZ.size() > 0 && out_ready) void'(qZ.pop_front());
        if (in_valid && mRdyZ) qZ.push_back(e);
      end
      if (qA.size() > 0) lastA = qA[0].d;
      if (qZ.size() > 0) lastZ = qZ[0].d;
    end
  end

  always @(negedge clk) begin
    check("A_valid", vldA, qA.size() > 0);
    check("A_ready", rdyA, qA.size() < 2);
    check("A_ctrl",  ctlA, (qA.size() > 0) ? qA[0].c : BUB);
    check("A_data",  datA, (qA.size() > 0) ? qA[0].d : lastA);
    check("A_stall", cntA, mCntA);
    check("S4_valid", vld4, qA.size() > 0);
    check("S4_ready", rdy4, qA.size() < 2);
    check("S4_ctrl",  ctl4, (qA.size() > 0) ? qA[0].c : BUB);
    check("S4_stall", cnt4, mCnt4);
    check("Z_valid", vldZ, qZ.size() > 0);
    check("Z_ready", rdyZ, (qZ.size() == 0) || out_ready);
    check("Z_ctrl",  ctlZ, (qZ.size() > 0) ? qZ[0].c : BUB);
    check("Z_data",  datZ, (qZ.size() > 0) ? qZ[0].d : lastZ);
    check("Z_stall", cntZ, mCntZ);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", vldA, 1'b0);
    check("rst_ctrl", ctlA, BUB);
    check("rst_data", datA, 96'h0);
    check("rst_stall", cntA, 16'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", rdyA, 1'b1);
    check("rst_readyZ", rdyZ, 1'b1);

    // Single transfer appears one cycle later
    in_valid = 1'b1; in_ctrl = 10'h3A5; in_data = 96'h1234; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("t1_valid", vldA, 1'b1);
    check("t1_ctrl", ctlA, 10'h3A5);
    check("t1_data", datA, 96'h1234);
    check("t1_stall", cntA, 16'd0);
    cyc();
    check("t1_empty", vldA, 1'b0);
    check("t1_bubble", ctlA, BUB);
    check("t1_hold", datA, 96'h1234);

    // Push A then B while downstream stalls; drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h0A1; in_data = 96'hAAAA_0001;
    cyc();
    in_ctrl = 10'h0B2; in_data = 96'hBBBB_0002;
    cyc();
    in_valid = 1'b0;
    check("t2_ready_low", rdyA, 1'b0);
    cyc();
    cyc();
    check("t2_stall", cntA, 16'd3);
    check("t2_headA", ctlA, 10'h0A1);
    out_ready = 1'b1;
    cyc();
    check("t2_headB", ctlA, 10'h0B2);
    check("t2_dataB", datA, 96'hBBBB_0002);
    check("t2_ready_back", rdyA, 1'b1);
    cyc();
    check("t2_drained", vldA, 1'b0);

    // Flush in skid state beats a simultaneous input
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h0C1; in_data = 96'hC1;
    cyc();
    in_ctrl = 10'h0C2; in_data = 96'hC2;
    cyc();
    check("t3_skid", rdyA, 1'b0);
    flush = 1'b1; in_ctrl = 10'h0C3; in_data = 96'hC3;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("t3_valid", vldA, 1'b0);
    check("t3_ctrl", ctlA, BUB);
    check("t3_ready", rdyA, 1'b1);
    check("t3_stall", cntA, 16'd5);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("t3_no_C", vldA, 1'b0);

    // Back-to-back stream at full throughput
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_ctrl = CW'(10'h100 + i); in_data = DW'(1000 + i);
      cyc();
      check("t4_valid", vldA, 1'b1);
      check("t4_data", datA, DW'(1000 + i));
      check("t4_ready", rdyA, 1'b1);
    end
    in_valid = 1'b0;

    // Long stall: 4-bit counter saturates, 16-bit keeps counting
    out_ready = 1'b0;
    repeat (20) cyc();
    check("t5_sat", cnt4, 4'd15);
    check("t5_cnt", cntA, 16'd25);
    check("t5_held", datA, DW'(1007));

    // No-skid ready is combinational from out_ready; async reset mid-cycle
    check("t6_valid", vldZ, 1'b1);
    check("t6_ready_low", rdyZ, 1'b0);
    out_ready = 1'b1;
    #1;
    check("t6_ready_comb", rdyZ, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_validZ", vldZ, 1'b0);
    check("t6_rst_ctrlZ", ctlZ, BUB);
    check("t6_rst_validA", vldA, 1'b0);
    check("t6_rst_stall", cntA, 16'd0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
